// File: rtl/mbist_march_engine_if.sv
// Bus bundle between the MBIST march engine and its surroundings: the BIST
// control/status signals plus the single-port SRAM pins.
interface mbist_march_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              BIST_EN;
    logic [2:0]        BIST_MODE;
    logic [DATA_W-1:0] BIST_BG;
    logic              BIST_BUSY;
    logic              BIST_DONE;
    logic              BIST_PASS;
    logic [CNT_W-1:0]  FAIL_CNT;
    logic [ADDR_W-1:0] FAIL_ADDR;
    logic [DATA_W-1:0] FAIL_DATA;
    logic              MEM_CSB;
    logic              MEM_WEB;
    logic              MEM_OEB;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;

    // Engine side
    modport slave (
        input  BIST_EN, BIST_MODE, BIST_BG, MEM_RDATA,
        output BIST_BUSY, BIST_DONE, BIST_PASS, FAIL_CNT, FAIL_ADDR, FAIL_DATA,
               MEM_CSB, MEM_WEB, MEM_OEB, MEM_ADDR, MEM_WDATA
    );

    // Controller / memory side
    modport master (
        output BIST_EN, BIST_MODE, BIST_BG, MEM_RDATA,
        input  BIST_BUSY, BIST_DONE, BIST_PASS, FAIL_CNT, FAIL_ADDR, FAIL_DATA,
               MEM_CSB, MEM_WEB, MEM_OEB, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mbist_march_engine.sv
// Memory BIST march engine: runs MATS+, March C- or checkerboard over a
// single-port SRAM, compares every read after RD_LAT cycles and keeps a
// saturating fail count plus first-fail address/data.
module mbist_march_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    mbist_march_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // One march element: up to two ops applied to each address.
    // rdX = op is a read, vX = data polarity (0 -> BG, 1 -> ~BG).
    typedef struct packed {
        logic last;
        logic two;
        logic rd0;
        logic v0;
        logic rd1;
        logic v1;
    } elem_t;

    function automatic elem_t elem_info(input logic [2:0] mode, input logic [2:0] idx);
        elem_t e;
        e = 6'b100000;
        case (mode)
            3'b001: case (idx)                    // MATS+
                3'd0:    e = 6'b000000;           // w0
                3'd1:    e = 6'b011001;           // r0,w1
                3'd2:    e = 6'b111100;           // r1,w0
                default: e = 6'b100000;
            endcase
            3'b010: case (idx)                    // March C-
                3'd0:    e = 6'b000000;           // w0
                3'd1:    e = 6'b011001;           // r0,w1
                3'd2:    e = 6'b011100;           // r1,w0
                3'd3:    e = 6'b011001;           // r0,w1
                3'd4:    e = 6'b011100;           // r1,w0
                3'd5:    e = 6'b101000;           // r0
                default: e = 6'b100000;
            endcase
            3'b100: case (idx)                    // checkerboard
                3'd0:    e = 6'b000000;           // wC
                3'd1:    e = 6'b001000;           // rC
                3'd2:    e = 6'b000100;           // w~C
                3'd3:    e = 6'b101100;           // r~C
                default: e = 6'b100000;
            endcase
            default: e = 6'b100000;
        endcase
        return e;
    endfunction

    // Address direction of an element: 1 = descending N-1..0.
    function automatic logic elem_down(input logic [2:0] mode, input logic [2:0] idx);
        logic d;
        d = 1'b0;
        if (mode == 3'b001 && idx == 3'd2)
            d = 1'b1;
        if (mode == 3'b010 && (idx == 3'd3 || idx == 3'd4))
            d = 1'b1;
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [DATA_W-1:0] bg_q, bg_d;
    logic              mode_ok_q, mode_ok_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        drain_q, drain_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    // Read-compare pipeline: stage RD_LAT-1 lines up with MEM_RDATA.
    logic              pipe_vld_q  [RD_LAT];
    logic              pipe_vld_d  [RD_LAT];
    logic [DATA_W-1:0] pipe_exp_q  [RD_LAT];
    logic [DATA_W-1:0] pipe_exp_d  [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr_d [RD_LAT];

    elem_t             info;
    logic              cur_down;
    logic              cur_rd;
    logic              cur_val;
    logic [DATA_W-1:0] cur_data;
    logic              addr_end;
    logic              mode_onehot;

    // Decode the op currently being driven from the element/op/address counters.
    always_comb begin
        info     = elem_info(mode_q, elem_q);
        cur_down = elem_down(mode_q, elem_q);
        cur_rd   = op_q ? info.rd1 : info.rd0;
        cur_val  = op_q ? info.v1 : info.v0;
        cur_data = bg_q ^ {DATA_W{cur_val ^ (mode_q[2] & addr_q[0])}};
        addr_end = cur_down ? (addr_q == '0) : (addr_q == '1);
        mode_onehot = (bus.BIST_MODE == 3'b001) || (bus.BIST_MODE == 3'b010) ||
                      (bus.BIST_MODE == 3'b100);
    end

    // Next-state: FSM, op sequencing, compare pipeline and fail capture.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        bg_d        = bg_q;
        mode_ok_d   = mode_ok_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        fail_cnt_d  = fail_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        pipe_vld_d[0]  = 1'b0;
        pipe_exp_d[0]  = pipe_exp_q[0];
        pipe_addr_d[0] = pipe_addr_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_exp_d[i]  = pipe_exp_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        // In-flight reads only count while the test is still enabled.
        if ((state_q == RUN || state_q == DRAIN) && bus.BIST_EN &&
            pipe_vld_q[RD_LAT-1] && (bus.MEM_RDATA != pipe_exp_q[RD_LAT-1])) begin
            if (fail_cnt_q == '0) begin
                fail_addr_d = pipe_addr_q[RD_LAT-1];
                fail_data_d = bus.MEM_RDATA;
            end
            if (fail_cnt_q != '1)
                fail_cnt_d = fail_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                for (int i = 0; i < RD_LAT; i++) pipe_vld_d[i] = 1'b0;
                if (bus.BIST_EN) begin
                    mode_d      = bus.BIST_MODE;
                    bg_d        = bus.BIST_BG;
                    fail_cnt_d  = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    elem_d      = 3'd0;
                    op_d        = 1'b0;
                    addr_d      = '0;
                    mode_ok_d   = mode_onehot;
                    state_d     = mode_onehot ? RUN : DONE;
                end
            end
            RUN: begin
                if (!bus.BIST_EN) begin
                    state_d = IDLE;
                    for (int i = 0; i < RD_LAT; i++) pipe_vld_d[i] = 1'b0;
                end else begin
                    if (cur_rd) begin
                        pipe_vld_d[0]  = 1'b1;
                        pipe_exp_d[0]  = cur_data;
                        pipe_addr_d[0] = addr_q;
                    end
                    if (op_q != info.two) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (addr_end) begin
                            if (info.last) begin
                                state_d = DRAIN;
                                drain_d = 3'd0;
                            end else begin
                                elem_d = elem_q + 3'd1;
                                addr_d = elem_down(mode_q, elem_q + 3'd1) ? '1 : '0;
                            end
                        end else begin
                            addr_d = cur_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!bus.BIST_EN) begin
                    state_d = IDLE;
                    for (int i = 0; i < RD_LAT; i++) pipe_vld_d[i] = 1'b0;
                end else if (drain_q == 3'(RD_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            DONE: begin
                for (int i = 0; i < RD_LAT; i++) pipe_vld_d[i] = 1'b0;
                if (!bus.BIST_EN)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            mode_q      <= 3'b000;
            bg_q        <= '0;
            mode_ok_q   <= 1'b0;
            elem_q      <= 3'd0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            drain_q     <= 3'd0;
            fail_cnt_q  <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_exp_q[i]  <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bg_q        <= bg_d;
            mode_ok_q   <= mode_ok_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_exp_q[i]  <= pipe_exp_d[i];
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    // Memory pins are only active in RUN; status decoded straight from the flops.
    assign bus.MEM_CSB   = (state_q != RUN);
    assign bus.MEM_WEB   = !((state_q == RUN) && !cur_rd);
    assign bus.MEM_OEB   = !((state_q == RUN) && cur_rd);
    assign bus.MEM_ADDR  = (state_q == RUN) ? addr_q : '0;
    assign bus.MEM_WDATA = ((state_q == RUN) && !cur_rd) ? cur_data : '0;
    assign bus.BIST_BUSY = (state_q == RUN) || (state_q == DRAIN);
    assign bus.BIST_DONE = (state_q == DONE);
    assign bus.BIST_PASS = (state_q == DONE) && mode_ok_q && (fail_cnt_q == '0);
    assign bus.FAIL_CNT  = fail_cnt_q;
    assign bus.FAIL_ADDR = fail_addr_q;
    assign bus.FAIL_DATA = fail_data_q;
endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: two engines (RD_LAT=1/CNT_W=8 and
// RD_LAT=2/CNT_W=2) run the same stimulus against behavioural SRAMs with an
// injectable per-address fault, checked against a march-algorithm model.
`timescale 1ns/1ps
module tb_mbist_march_engine;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    mbist_march_engine_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(8)) ifa ();
    mbist_march_engine_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) ifb ();

    mbist_march_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CNT_W(8))
        dut_a (.CLK(CLK), .RSTN(RSTN), .bus(ifa));
    mbist_march_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .CNT_W(2))
        dut_b (.CLK(CLK), .RSTN(RSTN), .bus(ifb));

    int n_err = 0;
    int n_chk = 0;

    // ---------------- fault-injectable SRAM models ----------------
    int         fa  = 0;
    logic [7:0] s1m = 8'h00;
    logic [7:0] s0m = 8'h00;

    function automatic logic [7:0] rd_fault(input logic [7:0] d, input logic [3:0] a);
        return (a == 4'(fa)) ? ((d | s1m) & ~s0m) : d;
    endfunction

    logic [7:0] mem_a [N];
    logic [7:0] mem_b [N];
    logic [7:0] pa0, pb0, pb1;

    always @(posedge CLK) begin
        if (!ifa.MEM_CSB && !ifa.MEM_WEB) mem_a[ifa.MEM_ADDR] <= ifa.MEM_WDATA;
        pa0 <= (!ifa.MEM_CSB && ifa.MEM_WEB) ? rd_fault(mem_a[ifa.MEM_ADDR], ifa.MEM_ADDR) : 8'hEE;
        if (!ifb.MEM_CSB && !ifb.MEM_WEB) mem_b[ifb.MEM_ADDR] <= ifb.MEM_WDATA;
        pb0 <= (!ifb.MEM_CSB && ifb.MEM_WEB) ? rd_fault(mem_b[ifb.MEM_ADDR], ifb.MEM_ADDR) : 8'hEE;
        pb1 <= pb0;
    end
    assign ifa.MEM_RDATA = pa0;
    assign ifb.MEM_RDATA = pb1;

    // ---------------- reference model ----------------
    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;
    op_t exp_q[$];

    // Expand the algorithm into its op list and run it on an ideal memory with the fault.
    task automatic build_model(input logic [2:0] mode, input logic [7:0] bg,
                               output int nfail, output logic [3:0] faddr, output logic [7:0] fdata);
        string      el[$];
        logic [7:0] m [N];
        logic [7:0] d, r;
        logic [3:0] a;
        op_t        o;
        exp_q.delete();
        nfail = 0; faddr = 4'h0; fdata = 8'h00;
        for (int i = 0; i < N; i++) m[i] = 8'h00;
        if (mode == 3'b001) begin
            el.push_back("^w0"); el.push_back("^r0w1"); el.push_back("vr1w0");
        end else if (mode == 3'b010) begin
            el.push_back("^w0"); el.push_back("^r0w1"); el.push_back("^r1w0");
            el.push_back("vr0w1"); el.push_back("vr1w0"); el.push_back("^r0");
        end else begin
            el.push_back("^w0"); el.push_back("^r0"); el.push_back("^w1"); el.push_back("^r1");
        end
        foreach (el[e]) begin
            for (int s = 0; s < N; s++) begin
                a = (el[e].getc(0) == "v") ? 4'(N - 1 - s) : 4'(s);
                for (int p = 1; p < el[e].len(); p += 2) begin
                    d = bg ^ {8{el[e].getc(p + 1) == "1"}};
                    if (mode == 3'b100 && a[0]) d = ~d;
                    o.we = (el[e].getc(p) == "w");
                    o.addr = a;
                    o.data = d;
                    exp_q.push_back(o);
                    if (o.we) begin
                        m[a] = d;
                    end else begin
                        r = rd_fault(m[a], a);
                        if (r != d) begin
                            if (nfail == 0) begin faddr = a; fdata = r; end
                            nfail++;
                        end
                    end
                end
            end
        end
    endtask

    function automatic bit op_ok(input int k, input int m, input logic csb, input logic web,
                                 input logic oeb, input logic [3:0] a, input logic [7:0] wd);
        if (k >= m) return csb;
        if (csb) return 1'b0;
        if (exp_q[k].we) return !web && oeb && (a == exp_q[k].addr) && (wd == exp_q[k].data);
        return web && !oeb && (a == exp_q[k].addr);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] mode, input logic [7:0] bg);
        ifa.BIST_EN = en; ifa.BIST_MODE = mode; ifa.BIST_BG = bg;
        ifb.BIST_EN = en; ifb.BIST_MODE = mode; ifb.BIST_BG = bg;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_a"}, 64'({ifa.MEM_CSB, ifa.MEM_WEB, ifa.MEM_OEB, ifa.MEM_ADDR, ifa.MEM_WDATA,
                             ifa.BIST_BUSY, ifa.BIST_DONE, ifa.BIST_PASS,
                             ifa.FAIL_CNT, ifa.FAIL_ADDR, ifa.FAIL_DATA}), 64'({3'b111, 35'd0}));
        chk({nm, "_b"}, 64'({ifb.MEM_CSB, ifb.MEM_WEB, ifb.MEM_OEB, ifb.MEM_ADDR, ifb.MEM_WDATA,
                             ifb.BIST_BUSY, ifb.BIST_DONE, ifb.BIST_PASS,
                             ifb.FAIL_CNT, ifb.FAIL_ADDR, ifb.FAIL_DATA}), 64'({3'b111, 29'd0}));
    endtask

    // Full run on both engines; expectations supplied by the caller.
    task automatic run_alg(input string nm, input logic [2:0] mode, input logic [7:0] bg,
                           input int ops, input bit epass, input int ecnt,
                           input logic [3:0] efa, input logic [7:0] efd);
        int nf, m, k, done_a, done_b, bad_a, bad_b, ncs, nw;
        logic [3:0] mfa;
        logic [7:0] mfd, wd0, wd1;
        build_model(mode, bg, nf, mfa, mfd);
        m = exp_q.size();
        @(negedge CLK);
        drive(1'b1, mode, bg);
        @(posedge CLK);
        k = 0; done_a = -1; done_b = -1; bad_a = 0; bad_b = 0; ncs = 0; nw = 0;
        wd0 = 8'h00; wd1 = 8'h00;
        while ((done_a < 0 || done_b < 0) && k < m + 40) begin
            @(negedge CLK);
            if (k == 7) drive(1'b1, 3'($urandom), 8'($urandom));
            if (!op_ok(k, m, ifa.MEM_CSB, ifa.MEM_WEB, ifa.MEM_OEB, ifa.MEM_ADDR, ifa.MEM_WDATA)) bad_a++;
            if (!op_ok(k, m, ifb.MEM_CSB, ifb.MEM_WEB, ifb.MEM_OEB, ifb.MEM_ADDR, ifb.MEM_WDATA)) bad_b++;
            if (!ifa.MEM_CSB) begin
                ncs++;
                if (!ifa.MEM_WEB) begin
                    if (nw == 0) wd0 = ifa.MEM_WDATA;
                    if (nw == 1) wd1 = ifa.MEM_WDATA;
                    nw++;
                end
            end
            if (done_a < 0 && ifa.BIST_DONE) done_a = k;
            if (done_b < 0 && ifb.BIST_DONE) done_b = k;
            k++;
        end
        chk({nm, "_done_cyc_a"}, 64'(done_a), 64'(ops * N + 1));
        chk({nm, "_done_cyc_b"}, 64'(done_b), 64'(ops * N + 2));
        chk({nm, "_ops_a"}, 64'(bad_a), 64'd0);
        chk({nm, "_ops_b"}, 64'(bad_b), 64'd0);
        chk({nm, "_csb_cnt"}, 64'(ncs), 64'(ops * N));
        chk({nm, "_pass"}, 64'({ifa.BIST_PASS, ifb.BIST_PASS}), 64'({epass, epass}));
        chk({nm, "_cnt_a"}, 64'(ifa.FAIL_CNT), 64'(ecnt > 255 ? 255 : ecnt));
        chk({nm, "_cnt_b"}, 64'(ifb.FAIL_CNT), 64'(ecnt > 3 ? 3 : ecnt));
        chk({nm, "_fdiag_a"}, 64'({ifa.FAIL_ADDR, ifa.FAIL_DATA}), 64'({efa, efd}));
        chk({nm, "_fdiag_b"}, 64'({ifb.FAIL_ADDR, ifb.FAIL_DATA}), 64'({efa, efd}));
        if (mode == 3'b100) chk({nm, "_cb_first_wr"}, 64'({wd0, wd1}), 64'({bg, ~bg}));
        repeat (3) @(negedge CLK);
        chk({nm, "_hold"}, 64'({ifa.BIST_DONE, ifb.BIST_DONE, ifa.MEM_CSB, ifb.MEM_CSB}), 64'hF);
        drive(1'b0, mode, bg);
        @(negedge CLK);
        chk({nm, "_idle"}, 64'({ifa.BIST_DONE, ifb.BIST_DONE, ifa.BIST_PASS, ifb.BIST_BUSY}), 64'h0);
        $display("run %s mode=%b bg=%h done_a=%0d done_b=%0d cnt_a=%0d cnt_b=%0d pass=%0b",
                 nm, mode, bg, done_a, done_b, ifa.FAIL_CNT, ifb.FAIL_CNT, epass);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      nm;
        logic [2:0] mode;
        logic [7:0] bg;
        int         fa;
        logic [7:0] s1;
        logic [7:0] s0;
        int         ops;
        bit         pass;
        int         cnt;
        logic [3:0] faddr;
        logic [7:0] fdata;
    } vec_t;
    vec_t tab[5];

    initial begin
        int nd, ncs, nf;
        logic [3:0] mfa;
        logic [7:0] mfd, bg;
        logic [2:0] mode;

        tab[0] = '{"mats_good",    3'b001, 8'h00, 0,  8'h00, 8'h00, 5,  1'b1, 0, 4'h0, 8'h00};
        tab[1] = '{"marchc_sa1",   3'b010, 8'h00, 5,  8'h01, 8'h00, 10, 1'b0, 3, 4'h5, 8'h01};
        tab[2] = '{"cb_good",      3'b100, 8'h55, 0,  8'h00, 8'h00, 4,  1'b1, 0, 4'h0, 8'h00};
        tab[3] = '{"marchc_word",  3'b010, 8'h00, 3,  8'h0F, 8'hF0, 10, 1'b0, 5, 4'h3, 8'h0F};
        tab[4] = '{"cb_sa0",       3'b100, 8'hA5, 10, 8'h00, 8'h80, 4,  1'b0, 1, 4'hA, 8'h25};

        drive(1'b0, 3'b000, 8'h00);
        @(negedge CLK);
        chk_reset("reset");
        RSTN = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            fa = tab[i].fa; s1m = tab[i].s1; s0m = tab[i].s0;
            run_alg(tab[i].nm, tab[i].mode, tab[i].bg, tab[i].ops, tab[i].pass,
                    tab[i].cnt, tab[i].faddr, tab[i].fdata);
        end
        s1m = 8'h00; s0m = 8'h00;

        // Illegal mode: straight to DONE with PASS low, no memory access
        @(negedge CLK);
        drive(1'b1, 3'b011, 8'h3C);
        @(posedge CLK);
        @(negedge CLK);
        chk("badmode_done", 64'({ifa.BIST_DONE, ifb.BIST_DONE, ifa.BIST_PASS, ifb.BIST_PASS}), 64'hC);
        ncs = 0;
        repeat (5) begin
            if (!ifa.MEM_CSB || !ifb.MEM_CSB) ncs++;
            @(negedge CLK);
        end
        chk("badmode_csb", 64'(ncs), 64'd0);
        chk("badmode_hold", 64'({ifa.BIST_DONE, ifb.BIST_DONE}), 64'h3);
        drive(1'b0, 3'b000, 8'h00);
        @(negedge CLK);
        chk("badmode_idle", 64'({ifa.BIST_DONE, ifb.BIST_DONE}), 64'h0);
        $display("run badmode mode=011 csb_active=%0d", ncs);

        // Abort 20 cycles after T1, then restart
        drive(1'b1, 3'b001, 8'h00);
        @(posedge CLK);
        repeat (21) @(negedge CLK);
        chk("abort_busy_before", 64'({ifa.BIST_BUSY, ifb.BIST_BUSY, ifa.MEM_CSB}), 64'h6);
        drive(1'b0, 3'b001, 8'h00);
        @(negedge CLK);
        chk("abort_after", 64'({ifa.MEM_CSB, ifb.MEM_CSB, ifa.BIST_BUSY, ifb.BIST_BUSY}), 64'hC);
        nd = 0;
        repeat (100) begin
            @(negedge CLK);
            if (ifa.BIST_DONE || ifb.BIST_DONE) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        $display("run abort mats+ done_seen=%0d", nd);
        run_alg("restart", 3'b001, 8'h00, 5, 1'b1, 0, 4'h0, 8'h00);

        // Asynchronous reset mid-run with a failure already recorded
        fa = 0; s1m = 8'hFF; s0m = 8'h00;
        @(negedge CLK);
        drive(1'b1, 3'b001, 8'h00);
        @(posedge CLK);
        repeat (30) @(negedge CLK);
        chk("midrun_cnt", 64'({ifa.FAIL_CNT, 6'd0, ifb.FAIL_CNT}), 64'({8'd1, 6'd0, 2'd1}));
        RSTN = 1'b0;
        #1;
        chk_reset("midrun_reset");
        drive(1'b0, 3'b000, 8'h00);
        @(negedge CLK);
        chk_reset("midrun_reset_held");
        RSTN = 1'b1;
        s1m = 8'h00;
        $display("run async_reset mid-run");

        // Randomised runs against the model
        for (int r = 0; r < 6; r++) begin
            mode = 3'(1 << $urandom_range(0, 2));
            bg   = 8'($urandom);
            fa   = $urandom_range(0, 15);
            s1m  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            s0m  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin s1m = 8'h00; s0m = 8'h00; end
            build_model(mode, bg, nf, mfa, mfd);
            run_alg($sformatf("rand%0d", r), mode, bg,
                    (mode == 3'b001) ? 5 : (mode == 3'b010) ? 10 : 4,
                    nf == 0, nf, mfa, mfd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
